// File: rtl/systick_match_irq.sv
// systick_match_irq
// Compare and interrupt stage behind the 24-bit systick counter.
// A match between the running count and the compare value becomes a single
// edge event. That event:
//   - pulses match_o,
//   - optionally requests a counter reload,
//   - advances a small pending/overrun interrupt FSM.
// While an interrupt is still pending, further matches are counted in a
// saturating miss counter.
// stint_clr doubles as the software interrupt-clear path. It is the only way
// out of the pending states.

module systick_match_irq #(
  parameter int CW = 24,
  parameter int MW = 8
) (
  input  logic          systick_clk,
  input  logic          stint_clr,
  input  logic [CW-1:0] cnt_i,
  input  logic [CW-1:0] cmp_i,
  input  logic          int_en_i,
  input  logic          periodic_i,
  input  logic          pause_i,
  output logic          match_o,
  output logic          cnt_reload_o,
  output logic          irq_o,
  output logic          overrun_o,
  output logic [MW-1:0] miss_cnt_o,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    OVR  = 2'b10
  } state_t;

  localparam logic [MW-1:0] MISS_MAX = '1;

  state_t        state;
  state_t        state_next;
  logic          match_raw;
  logic          match_q;
  logic          match_event;
  logic          fsm_step;
  logic [MW-1:0] miss_cnt;

  // A compare value of zero disables matching entirely.
  assign match_raw   = (cmp_i != '0) && (cnt_i == cmp_i);
  assign match_event = match_raw && !match_q && !pause_i;
  assign fsm_step    = match_event && int_en_i;

  // Remember the previous match level. It is frozen while paused, so a count
  // parked on the compare value cannot re-fire when the pause ends.
  always_ff @(posedge systick_clk or posedge stint_clr) begin
    if (stint_clr) begin
      match_q <= 1'b0;
    end else if (!pause_i) begin
      match_q <= match_raw;
    end
  end

  // Register the one-cycle event pulse and the periodic reload request.
  always_ff @(posedge systick_clk or posedge stint_clr) begin
    if (stint_clr) begin
      match_o      <= 1'b0;
      cnt_reload_o <= 1'b0;
    end else begin
      match_o      <= match_event;
      cnt_reload_o <= match_event && periodic_i;
    end
  end

  // Interrupt FSM state register.
  always_ff @(posedge systick_clk or posedge stint_clr) begin
    if (stint_clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: only enabled match events move the FSM forward.
  always_comb begin
    state_next = state;
    if (fsm_step) begin
      case (state)
        IDLE:    state_next = PEND;
        PEND:    state_next = OVR;
        OVR:     state_next = OVR;
        default: state_next = IDLE;
      endcase
    end
  end

  // Count enabled events that arrive while an interrupt is already pending.
  // The counter saturates rather than wrapping.
  always_ff @(posedge systick_clk or posedge stint_clr) begin
    if (stint_clr) begin
      miss_cnt <= '0;
    end else if (fsm_step && (state != IDLE) && (miss_cnt != MISS_MAX)) begin
      miss_cnt <= miss_cnt + 1'b1;
    end
  end

  // Decode the interrupt outputs from the registered state.
  always_comb begin
    irq_o     = (state != IDLE);
    overrun_o = (state == OVR);
    state_o   = state;
  end

  assign miss_cnt_o = miss_cnt;

endmodule

// File: doc/systick_match_irq.md
Name: systick_match_irq

Overview:
- Synchronous compare and interrupt stage downstream of the 24-bit systick counter.
- Samples the running count against a compare value and detects the match as a single edge event.
- Keeps a pending/overrun interrupt state and counts missed ticks while an interrupt is still pending.
- In periodic mode, issues a one-cycle reload request back to the counter.

Parameters:
CW, 24, counter and compare width
MW, 8, width of saturating missed-tick counter

Ports:
systick_clk  in  1  counter clock; all state updates on rising edge
stint_clr  in  1  reset: asynchronous, active-high; also the software interrupt-clear path
cnt_i  in  CW  current systick count, stable in systick_clk domain
cmp_i  in  CW  compare value {STK2,STK1,STK0}; 0 = compare disabled
int_en_i  in  1  interrupt enable (TIMC bit)
periodic_i  in  1  1 = request counter reload on each match event
pause_i  in  1  counter paused (SYST_PAUSE & pause-enable); freezes edge detection
match_o  out  1  one-cycle match event pulse, registered
cnt_reload_o  out  1  one-cycle counter reload request, registered
irq_o  out  1  interrupt level, registered
overrun_o  out  1  at least one match while interrupt already pending
miss_cnt_o  out  MW  count of matches lost while pending, saturating
state_o  out  2  FSM state: 00 IDLE, 01 PEND, 10 OVR

Behaviour:
- Reset (stint_clr=1, async):
  - match_q=0; state=IDLE.
  - match_o, cnt_reload_o, irq_o, overrun_o = 0; miss_cnt_o = 0.
  - Reset dominates every other input. Reset asserted mid-pending drops irq_o immediately (asynchronously).
- Match detection:
  - match_raw = (cmp_i != 0) & (cnt_i == cmp_i).
  - event = match_raw & ~match_q & ~pause_i.
  - match_q <= match_raw only when pause_i=0; it holds while paused.
  - A count held at cmp during a pause therefore never re-fires.
  - A match that appears during a pause (e.g. cmp_i rewritten) fires on the first unpaused edge.
- Latency: when event is true before edge N, match_o=1 during cycle N to N+1 only. irq/state change at that same edge N.
- cnt_reload_o: equals event & periodic_i, registered at edge N (same cycle as match_o). Width is exactly one cycle; periodic_i is sampled at the event cycle only.
- FSM, evaluated only on event & int_en_i:
  - IDLE -> PEND.
  - PEND -> OVR; miss_cnt +1.
  - OVR -> OVR; miss_cnt +1, saturating at 2^MW-1 (no wrap).
- Events with int_en_i=0 still pulse match_o and cnt_reload_o but cause no FSM or miss_cnt change.
- Clearing int_en_i does not clear a pending state. The only exit from PEND or OVR is stint_clr.
- Outputs: irq_o = (state != IDLE), registered with the state. overrun_o = (state == OVR).
- cmp_i = 0: no events ever. Count wrap 2^CW-1 -> 0 is a normal transition (cmp = 2^CW-1 fires once per wrap).
- Back-to-back matches: an event requires a 0 -> 1 transition of match_q. Counts differing by one cycle (cmp equal in consecutive cycles only if cnt holds) therefore produce one event.

Test Plan:
- Reset release; cmp=5, int_en=1, periodic=0; cnt ramps 0..7 -> match_o and irq_o rise at the edge sampling cnt=5. match_o is 1 cycle wide, irq_o stays 1, state=01, cnt_reload_o=0.
- periodic=1, cmp=3; counter reloads to 0 on cnt_reload_o -> match pulses every 4 cycles. Second pulse: state=10, overrun_o=1, miss_cnt=1. After 300 further matches with MW=8, miss_cnt=255 (saturated).
- pause_i=1 while cnt held at cmp=9 for 10 cycles -> single match_o. During the pause, change cmp from 12 to 9 with cnt=9 held -> match_o fires on the first cycle after pause_i falls.
- int_en=0, cmp=4, counter runs through 4 twice -> two match_o pulses, irq_o=0, state=00, miss_cnt=0. Set int_en=1 on the next match -> irq_o=1.
- Assert stint_clr asynchronously mid-cycle while state=OVR, miss_cnt=7 -> irq_o, overrun_o and miss_cnt_o drop to 0 without waiting for a clock edge. The next match after release -> state=01.
- cmp=0, counter wraps through 0 repeatedly -> no match_o. cmp=2^24-1 -> exactly one event per wrap.
